// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller running off a single system clock, advanced by tck_en strobes.
// Holds the instruction register plus the BYPASS and IDCODE data registers, and drives an external boundary scan chain.
module tap_controller #(
    parameter logic [31:0] IDCODE   = 32'h1000_0001,
    parameter int          IR_WIDTH = 4
) (
    input  logic       ICLK,
    input  logic       rst,
    input  logic       tck_en,
    input  logic       tms,
    input  logic       tdi,
    input  logic       bsr_so,
    output logic       tdo,
    output logic       tdo_en,
    output logic       bsr_si,
    output logic       shift_dr,
    output logic       clk_dr,
    output logic       update_dr,
    output logic       mode,
    output logic [3:0] tap_state
);
    // state  | meaning
    // TLR    | test-logic-reset, instruction forced to IDCODE
    // RTI    | run-test/idle
    // SEL_DR | select DR scan
    // CAP_DR | capture into the selected data register
    // SH_DR  | shift the selected data register
    // EX1_DR | exit1 DR
    // PA_DR  | pause DR
    // EX2_DR | exit2 DR
    // UPD_DR | update DR
    // SEL_IR | select IR scan
    // CAP_IR | capture fixed pattern into the IR shifter
    // SH_IR  | shift the IR shifter
    // EX1_IR | exit1 IR
    // PA_IR  | pause IR
    // EX2_IR | exit2 IR
    // UPD_IR | update IR
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } state_t;

    localparam logic [IR_WIDTH-1:0] INSTR_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] INSTR_SAMPLE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE   = IR_WIDTH'(5);

    state_t              state;
    state_t              next_state;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass;
    logic [31:0]         idreg;
    logic                sel_chain;
    logic                sel_id;

    always_comb begin
        next_state = TLR;
        case (state)
            TLR:    next_state = tms ? TLR    : RTI;
            RTI:    next_state = tms ? SEL_DR : RTI;
            SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
            CAP_DR: next_state = tms ? EX1_DR : SH_DR;
            SH_DR:  next_state = tms ? EX1_DR : SH_DR;
            EX1_DR: next_state = tms ? UPD_DR : PA_DR;
            PA_DR:  next_state = tms ? EX2_DR : PA_DR;
            EX2_DR: next_state = tms ? UPD_DR : SH_DR;
            UPD_DR: next_state = tms ? SEL_DR : RTI;
            SEL_IR: next_state = tms ? TLR    : CAP_IR;
            CAP_IR: next_state = tms ? EX1_IR : SH_IR;
            SH_IR:  next_state = tms ? EX1_IR : SH_IR;
            EX1_IR: next_state = tms ? UPD_IR : PA_IR;
            PA_IR:  next_state = tms ? EX2_IR : PA_IR;
            EX2_IR: next_state = tms ? UPD_IR : SH_IR;
            UPD_IR: next_state = tms ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    always_ff @(posedge ICLK or posedge rst) begin
        if (rst) begin
            state    <= TLR;
            ir       <= INSTR_IDCODE;
            ir_shift <= IR_CAPTURE;
            bypass   <= 1'b0;
            idreg    <= IDCODE;
        end else if (tck_en) begin
            state <= next_state;
            case (state)
                CAP_IR: ir_shift <= IR_CAPTURE;
                SH_IR:  ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                CAP_DR: begin
                    bypass <= 1'b0;
                    idreg  <= IDCODE;
                end
                SH_DR: begin
                    bypass <= tdi;
                    idreg  <= {tdi, idreg[31:1]};
                end
                default: ;
            endcase
            // Entering TLR restores IDCODE on the same edge, so ir is never stale while in TLR.
            if (next_state == TLR)
                ir <= INSTR_IDCODE;
            else if (state == UPD_IR)
                ir <= ir_shift;
        end
    end

    assign sel_chain = (ir == INSTR_EXTEST) || (ir == INSTR_SAMPLE);
    assign sel_id    = (ir == INSTR_IDCODE);
    assign tap_state = state;

    always_comb begin
        tdo       = 1'b0;
        tdo_en    = 1'b0;
        bsr_si    = 1'b0;
        shift_dr  = 1'b0;
        clk_dr    = 1'b0;
        update_dr = 1'b0;
        mode      = 1'b0;
        if (!rst) begin
            tdo_en   = (state == SH_IR) || (state == SH_DR);
            shift_dr = (state == SH_DR);
            mode     = (ir == INSTR_EXTEST);
            bsr_si   = tdi;
            if (sel_chain) begin
                clk_dr    = tck_en && ((state == CAP_DR) || (state == SH_DR));
                update_dr = tck_en && (state == UPD_DR);
            end
            if (state == SH_IR)
                tdo = ir_shift[0];
            else if (state == SH_DR) begin
                if (sel_chain)
                    tdo = bsr_so;
                else if (sel_id)
                    tdo = idreg[0];
                else
                    tdo = bypass;
            end
        end
    end
endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: shift data goes through an expected-tdo queue drained by a monitor,
// static outputs and chain strobe counts are compared directly.
module tb_tap_controller;
    localparam logic [31:0] ID = 32'h1000_0001;

    logic       ICLK = 1'b0;
    logic       rst, tck_en, tms, tdi, bsr_so;
    logic       tdo, tdo_en, bsr_si, shift_dr, clk_dr, update_dr, mode;
    logic [3:0] tap_state;

    typedef struct {
        string name;
        logic  v;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    int   cnt_clk = 0;
    int   cnt_upd = 0;
    int   base_clk, base_upd;

    tap_controller #(.IDCODE(ID), .IR_WIDTH(4)) dut (
        .ICLK(ICLK), .rst(rst), .tck_en(tck_en), .tms(tms), .tdi(tdi), .bsr_so(bsr_so),
        .tdo(tdo), .tdo_en(tdo_en), .bsr_si(bsr_si), .shift_dr(shift_dr),
        .clk_dr(clk_dr), .update_dr(update_dr), .mode(mode), .tap_state(tap_state)
    );

    always #5 ICLK = ~ICLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Called at posedge+1; holds the strobe over exactly one rising edge.
    task automatic strobe(input logic m, input logic d);
        tms = m;
        tdi = d;
        tck_en = 1'b1;
        @(posedge ICLK);
        #1;
        tck_en = 1'b0;
    endtask

    task automatic pause_idle(input logic [3:0] st);
        for (int k = 0; k < 100; k++) begin
            tms = 1'($urandom);
            tdi = 1'($urandom);
            @(posedge ICLK);
            #1;
        end
        check("idle_tap_state", tap_state, st);
    endtask

    // From RTI: capture, shift n bits, update, back to RTI.
    task automatic dr_scan(input string nm, input int n, input logic [31:0] tdi_v,
                           input logic [31:0] exp_v, input logic use_bsr, input int pause_at);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        check({nm, "_shift_dr"}, shift_dr, 1);
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) pause_idle(4'd4);
            if (use_bsr) bsr_so = exp_v[i];
            q.push_back('{nm, exp_v[i]});
            strobe(i == n - 1, tdi_v[i]);
        end
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        check({nm, "_end_state"}, tap_state, 1);
        check({nm, "_shift_dr_idle"}, shift_dr, 0);
    endtask

    // From RTI: load an instruction; the capture pattern always reads back 1,0,1,0.
    task automatic ir_scan(input logic [3:0] code);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        check("ir_shift_state", tap_state, 11);
        for (int i = 0; i < 4; i++) begin
            q.push_back('{"ir_tdo", (i % 2) == 0});
            strobe(i == 3, code[i]);
        end
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        tck_en = 1'b0;
        tms = 1'b1;
        tdi = 1'b1;
        bsr_so = 1'b0;

        fork
            forever begin
                @(negedge ICLK);
                if (!rst && clk_dr) cnt_clk++;
                if (!rst && update_dr) cnt_upd++;
                if (tck_en && tdo_en) begin
                    if (q.size() == 0) begin
                        total++;
                        $display("FAIL tdo_unexpected: got tdo=%b with no expected value queued", tdo);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check(e.name, tdo, e.v);
                    end
                end
            end
        join_none

        repeat (3) @(posedge ICLK);
        #1;
        tck_en = 1'b1;
        tms = 1'b0;
        @(negedge ICLK);
        check("rst_tap_state", tap_state, 0);
        check("rst_tdo", tdo, 0);
        check("rst_tdo_en", tdo_en, 0);
        check("rst_bsr_si", bsr_si, 0);
        check("rst_mode", mode, 0);
        check("rst_clk_dr", clk_dr, 0);
        check("rst_update_dr", update_dr, 0);
        check("rst_shift_dr", shift_dr, 0);
        @(posedge ICLK);
        #1;
        tck_en = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0);
        check("tlr_after_5", tap_state, 0);
        check("tlr_mode", mode, 0);
        strobe(1'b0, 1'b1);
        check("rti_state", tap_state, 1);
        check("bsr_si_1", bsr_si, 1);
        tdi = 1'b0;
        #1;
        check("bsr_si_0", bsr_si, 0);

        // IDCODE readout with a 100-cycle strobe-free gap mid-shift.
        base_clk = cnt_clk;
        base_upd = cnt_upd;
        dr_scan("idcode", 32, 32'h0, ID, 1'b0, 16);
        check("idcode_clk_dr", cnt_clk - base_clk, 0);
        check("idcode_upd_dr", cnt_upd - base_upd, 0);

        // Pause-path walk through the DR column.
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
        check("ex1_dr", tap_state, 5);
        strobe(1'b0, 1'b0);
        check("pa_dr", tap_state, 6);
        strobe(1'b1, 1'b0);
        check("ex2_dr", tap_state, 7);
        strobe(1'b1, 1'b0);
        check("upd_dr", tap_state, 8);
        strobe(1'b0, 1'b0);

        ir_scan(4'b0000);
        check("extest_mode", mode, 1);
        base_clk = cnt_clk;
        base_upd = cnt_upd;
        dr_scan("extest", 8, 32'h0000_005A, 32'h0000_00C3, 1'b1, -1);
        check("extest_clk_dr", cnt_clk - base_clk, 9);
        check("extest_upd_dr", cnt_upd - base_upd, 1);

        ir_scan(4'b0001);
        check("sample_mode", mode, 0);
        base_clk = cnt_clk;
        base_upd = cnt_upd;
        dr_scan("sample", 5, 32'h0000_0013, 32'h0000_0016, 1'b1, -1);
        check("sample_clk_dr", cnt_clk - base_clk, 6);
        check("sample_upd_dr", cnt_upd - base_upd, 1);

        ir_scan(4'b1111);
        base_clk = cnt_clk;
        base_upd = cnt_upd;
        dr_scan("bypass", 3, 32'h5, 32'h2, 1'b0, -1);
        check("bypass_clk_dr", cnt_clk - base_clk, 0);
        check("bypass_upd_dr", cnt_upd - base_upd, 0);

        ir_scan(4'b0111);
        check("unk_mode", mode, 0);
        base_clk = cnt_clk;
        dr_scan("unknown", 3, 32'h5, 32'h2, 1'b0, -1);
        check("unknown_clk_dr", cnt_clk - base_clk, 0);

        ir_scan(4'b0010);
        dr_scan("idcode_ir", 8, 32'hFF, ID, 1'b0, -1);

        // TLR forces IDCODE back even after EXTEST was loaded.
        ir_scan(4'b0000);
        check("extest_mode2", mode, 1);
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0);
        check("tlr_state2", tap_state, 0);
        check("tlr_mode2", mode, 0);
        strobe(1'b0, 1'b0);

        // Five tms=1 strobes from deep in the IR column reach TLR.
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        q.push_back('{"sh_ir_exit", 1'b1});
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0);
        check("tlr_from_sh_ir", tap_state, 0);
        strobe(1'b0, 1'b0);

        // Reset in the middle of an EXTEST shift.
        ir_scan(4'b0000);
        base_upd = cnt_upd;
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bsr_so = 1'(i % 3 == 0);
            q.push_back('{"abort_tdo", 1'(i % 3 == 0)});
            strobe(1'b0, 1'b1);
        end
        rst = 1'b1;
        #1;
        check("abort_state", tap_state, 0);
        check("abort_mode", mode, 0);
        check("abort_tdo_en", tdo_en, 0);
        check("abort_shift_dr", shift_dr, 0);
        @(posedge ICLK);
        #1;
        strobe(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_strobe_ignored", tap_state, 0);
        check("abort_upd_dr", cnt_upd - base_upd, 0);
        strobe(1'b0, 1'b0);
        dr_scan("post_rst_id", 8, 32'h0, ID, 1'b0, -1);

        @(posedge ICLK);
        #1;
        check("tdo_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1000_0001, the 32-bit device ID captured in IDCODE Capture-DR; bit 0 SHALL be 1.
REQ-002 SHALL have parameter IR_WIDTH, default 4, the instruction register width; the encodings below are for the default of 4.
REQ-003 ICLK  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 tck_en  input  1  one-ICLK-cycle strobe marking one JTAG TCK rising edge; the TAP advances only on strobe cycles.
REQ-006 tms  input  1  test mode select, sampled when tck_en=1.
REQ-007 tdi  input  1  test data in, sampled when tck_en=1.
REQ-008 bsr_so  input  1  serial out of the external boundary scan chain.
REQ-009 tdo  output  1  test data out.
REQ-010 tdo_en  output  1  high in Shift-IR or Shift-DR.
REQ-011 bsr_si  output  1  serial in to the boundary scan chain; equals tdi.
REQ-012 shift_dr  output  1  chain shift/capture select (1 = shift).
REQ-013 clk_dr  output  1  one-cycle chain capture/shift strobe.
REQ-014 update_dr  output  1  one-cycle chain update strobe.
REQ-015 mode  output  1  chain output select (1 = drive from update latches).
REQ-016 tap_state  output  4  current TAP state code, for debug.

Function
REQ-017 The block SHALL implement the 16 IEEE 1149.1 TAP states and their TMS transitions, with codes 0-15 in this order: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
REQ-018 The state SHALL change only on ICLK edges with tck_en=1; with tck_en=0 all registers SHALL hold.
REQ-019 From any state, 5 consecutive strobes with tms=1 SHALL reach TLR.
REQ-020 Instructions: EXTEST=4'b0000, SAMPLE=4'b0001, IDCODE=4'b0010, BYPASS=4'b1111; every other code SHALL act as BYPASS.
REQ-021 On a strobe in CAP_IR, ir_shift SHALL load 4'b0101.
REQ-022 On a strobe in SH_IR, ir_shift SHALL become {tdi, ir_shift[3:1]}; tdo SHALL equal ir_shift[0] throughout SH_IR.
REQ-023 On a strobe in UPD_IR, ir SHALL load ir_shift; the new instruction SHALL be effective from the next ICLK cycle.
REQ-024 On any cycle with state TLR, ir SHALL be IDCODE.
REQ-025 BYPASS: on a strobe in CAP_DR, the bypass bit SHALL load 0; on a strobe in SH_DR it SHALL load tdi; tdo SHALL equal the bypass bit.
REQ-026 IDCODE: on a strobe in CAP_DR, the idreg SHALL load IDCODE; on a strobe in SH_DR it SHALL become {tdi, idreg[31:1]}; tdo SHALL equal idreg[0].
REQ-027 EXTEST/SAMPLE select the chain: clk_dr SHALL equal tck_en AND state in {CAP_DR, SH_DR}; update_dr SHALL equal tck_en AND state==UPD_DR; tdo SHALL equal bsr_so.
REQ-028 For any other instruction, clk_dr and update_dr SHALL be 0.
REQ-029 shift_dr SHALL be 1 exactly when state==SH_DR.
REQ-030 mode SHALL be 1 exactly when ir==EXTEST, independent of state.
REQ-031 tdo SHALL be 0 outside SH_IR and SH_DR.
REQ-032 tdo, clk_dr, update_dr and shift_dr SHALL be combinational from state, ir and the shift registers, with zero-cycle latency.
REQ-033 A tck_en strobe arriving in the same cycle as rst SHALL be ignored.

Reset
REQ-034 While rst=1, the block SHALL force: state=TLR, ir=IDCODE, ir_shift=4'b0101, bypass=0, idreg=IDCODE.
REQ-035 During reset all outputs SHALL be 0 except tap_state=0.
REQ-036 Reset SHALL take effect immediately, including mid-shift; no partial update SHALL reach ir or the chain.

Verification
REQ-037 rst pulse, then 5 strobes with tms=1 -> tap_state=0, ir=4'b0010, mode=0.
REQ-038 From TLR: tms 0,1,0,0, then 32 SH_DR strobes -> tdo sequence LSB-first equals 32'h1000_0001; clk_dr stays 0.
REQ-039 IR scan: CAP_IR, then shift tdi 0,0,0,0 -> tdo shows 1,0,1,0; after UPD_IR, mode=1; a following DR scan gives clk_dr pulses equal to 1+N for an N-bit shift and exactly one update_dr pulse.
REQ-040 Load 4'b1111 (or 4'b0111), then shift tdi=1,0,1 in SH_DR -> tdo shows 0,1,0 (one-bit delay); no clk_dr pulses.
REQ-041 Assert rst after 10 of 32 SH_DR strobes -> state=TLR immediately, ir=IDCODE, no update_dr pulse.
REQ-042 Hold tms and tdi toggling with tck_en=0 for 100 cycles -> tap_state and all registers unchanged.
